spi_slave_regif: RTL and testbench

- Dedicated SPI MODE 0 slave that acts as the responder to an SPI master. It turns SPI frames into register-file read and write cycles.
- SPI pins are oversampled in the clk_i domain through synchronizers. Frame format: one command byte (bit7 = R/W, bits6:0 = start address), followed by any number of data bytes at auto-incrementing addresses.
- Sits between the chip pins and a local register bank or peripheral CSR block.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_sync_edge.sv | 40 ++++
 rtl/spi_slave_regif.sv | 187 ++++++++++++++++++
 tb/tb_spi_slave_regif.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave register interface.
// - state_t    : frame-level FSM state encoding
// - rw_bit()   : position of the read/write flag inside the command byte
// - CMD_RW_BIT : read/write flag position for the default 8-bit byte
package spi_pkg;

  localparam int DEFAULT_BYTE_SIZE = 8;

  // The read/write flag always sits in the MSB of the command byte.
  function automatic int rw_bit(input int byte_size);
    return byte_size - 1;
  endfunction

  localparam int CMD_RW_BIT = rw_bit(DEFAULT_BYTE_SIZE);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    WDATA  = 3'd2,
    RFETCH = 3'd3,
    RDATA  = 3'd4
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for a single asynchronous pin, with single-cycle
// rise/fall pulses derived from the synchronized level.
// Ports:
//   clk_i    - system clock
//   rst_n_i  - asynchronous reset, active-low
//   d_i      - asynchronous input pin
//   q_o      - synchronized level
//   rise_o   - one-cycle pulse on a synchronized 0->1 transition
//   fall_o   - one-cycle pulse on a synchronized 1->0 transition
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Reset to the pin's idle level so no spurious edge appears after reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d_i};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign q_o    = r_sync[STAGES-1];
  assign rise_o = q_o & ~r_prev;
  assign fall_o = ~q_o & r_prev;

endmodule

// File: rtl/spi_slave_regif.sv
// SPI MODE 0 slave that turns SPI frames into register-file cycles.
// Frame: command byte (MSB = read/write, low bits = start address), then any
// number of data bytes at auto-incrementing addresses. All SPI pins are
// oversampled in the clk_i domain.
// Ports:
//   clk_i, rst_n_i          - system clock, async active-low reset
//   spi_ssn_i/clk_i/di_i    - SPI select, clock, MOSI (asynchronous)
//   spi_do_o, spi_do_oe_o   - MISO and its output enable
//   reg_addr_o/wdata_o      - register address and write data
//   reg_we_o, reg_re_o      - one-cycle write/read strobes
//   reg_rdata_i             - read data, valid one cycle after reg_re_o
//   frame_done_o            - one-cycle pulse when an active frame ends
//   busy_o                  - high whenever the FSM is not IDLE
module spi_slave_regif
  import spi_pkg::*;
#(
  parameter int BYTE_SIZE   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 spi_ssn_i,
  input  logic                 spi_clk_i,
  input  logic                 spi_di_i,
  output logic                 spi_do_o,
  output logic                 spi_do_oe_o,
  output logic [BYTE_SIZE-2:0] reg_addr_o,
  output logic [BYTE_SIZE-1:0] reg_wdata_o,
  output logic                 reg_we_o,
  output logic                 reg_re_o,
  input  logic [BYTE_SIZE-1:0] reg_rdata_i,
  output logic                 frame_done_o,
  output logic                 busy_o
);

  localparam int AW  = BYTE_SIZE - 1;
  localparam int CW  = $clog2(BYTE_SIZE + 1);
  localparam int RWB = rw_bit(BYTE_SIZE);
  localparam logic [CW-1:0] LAST_BIT = CW'(BYTE_SIZE - 1);

  logic w_ssn, w_ssn_rise, w_ssn_fall;
  logic w_sck, w_sck_rise, w_sck_fall;
  logic w_di, w_di_rise, w_di_fall;
  logic w_unused;

  state_t r_state, w_next_state;
  logic [CW-1:0]        r_bit_cnt;
  logic [BYTE_SIZE-2:0] r_rx;
  logic [BYTE_SIZE-1:0] r_tx;
  logic [AW-1:0]        r_addr;
  logic                 r_fetch_ph;
  logic                 r_do;
  logic                 w_re;
  logic                 w_byte_done;
  logic [BYTE_SIZE-1:0] w_rx_next;

  // Select idles high, so its synchronizer resets high to keep MISO disabled.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ssn (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(spi_ssn_i),
    .q_o(w_ssn), .rise_o(w_ssn_rise), .fall_o(w_ssn_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(spi_clk_i),
    .q_o(w_sck), .rise_o(w_sck_rise), .fall_o(w_sck_fall)
  );

  // MOSI goes through the same depth as SCK so it is aligned with sck_rise.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_di (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(spi_di_i),
    .q_o(w_di), .rise_o(w_di_rise), .fall_o(w_di_fall)
  );

  assign w_unused = ^{w_ssn_rise, w_ssn_fall, w_sck, w_di_rise, w_di_fall};

  assign w_rx_next   = {r_rx, w_di};
  assign w_byte_done = w_sck_rise && (r_bit_cnt == LAST_BIT);

  // Next-state logic; a deasserted select overrides every other event.
  always_comb begin
    w_next_state = r_state;
    w_re         = 1'b0;
    if (w_ssn) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next_state = CMD;
        CMD:     if (w_byte_done) w_next_state = w_rx_next[RWB] ? RFETCH : WDATA;
        WDATA:   w_next_state = WDATA;
        RFETCH: begin
          w_re = ~r_fetch_ph;
          if (r_fetch_ph) w_next_state = RDATA;
        end
        RDATA:   if (w_byte_done) w_next_state = RFETCH;
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Datapath: shifting, address tracking and registered strobes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_bit_cnt    <= '0;
      r_rx         <= '0;
      r_tx         <= '0;
      r_addr       <= '0;
      r_fetch_ph   <= 1'b0;
      r_do         <= 1'b0;
      reg_addr_o   <= '0;
      reg_wdata_o  <= '0;
      reg_we_o     <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      reg_we_o     <= 1'b0;
      frame_done_o <= 1'b0;
      if (w_ssn) begin
        r_bit_cnt  <= '0;
        r_fetch_ph <= 1'b0;
        r_do       <= 1'b0;
        if (r_state != IDLE) frame_done_o <= 1'b1;
      end else begin
        if (r_state != RDATA) r_do <= 1'b0;
        case (r_state)
          IDLE: r_bit_cnt <= '0;
          CMD: begin
            if (w_sck_rise) begin
              r_rx <= w_rx_next[BYTE_SIZE-2:0];
              if (w_byte_done) begin
                r_bit_cnt <= '0;
                r_addr    <= w_rx_next[AW-1:0];
                // Present the read address ahead of the first read strobe.
                if (w_rx_next[RWB]) reg_addr_o <= w_rx_next[AW-1:0];
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end
          WDATA: begin
            if (w_sck_rise) begin
              r_rx <= w_rx_next[BYTE_SIZE-2:0];
              if (w_byte_done) begin
                r_bit_cnt   <= '0;
                reg_we_o    <= 1'b1;
                reg_addr_o  <= r_addr;
                reg_wdata_o <= w_rx_next;
                r_addr      <= r_addr + 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end
          RFETCH: begin
            r_fetch_ph <= ~r_fetch_ph;
            if (r_fetch_ph) r_tx <= reg_rdata_i;
          end
          RDATA: begin
            if (w_sck_fall) begin
              r_do <= r_tx[BYTE_SIZE-1];
              r_tx <= {r_tx[BYTE_SIZE-2:0], 1'b0};
            end
            if (w_sck_rise) begin
              if (w_byte_done) begin
                r_bit_cnt  <= '0;
                r_addr     <= r_addr + 1'b1;
                reg_addr_o <= r_addr + 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end
          default: r_bit_cnt <= '0;
        endcase
      end
    end
  end

  assign reg_re_o    = w_re;
  assign spi_do_o    = r_do & (r_state == RDATA);
  assign spi_do_oe_o = ~w_ssn;
  assign busy_o      = (r_state != IDLE);

endmodule

// File: tb/tb_spi_slave_regif.sv
// Directed self-checking bench for spi_slave_regif: the bench acts as SPI
// master and as the register bank behind the slave.
module tb_spi_slave_regif;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ssn = 1'b1;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       miso, miso_oe;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we, reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       frame_done, busy;

  int total = 0;
  int bad = 0;

  logic [7:0] bank [128];
  int         we_cnt = 0;
  int         re_cnt = 0;
  int         fd_cnt = 0;
  logic [6:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic       re_seen = 1'b0;
  logic [6:0] re_addr = 7'h00;

  always #5 clk = ~clk;

  spi_slave_regif #(.BYTE_SIZE(8), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .spi_ssn_i(ssn), .spi_clk_i(sck),
    .spi_di_i(mosi), .spi_do_o(miso), .spi_do_oe_o(miso_oe),
    .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata), .reg_we_o(reg_we),
    .reg_re_o(reg_re), .reg_rdata_i(reg_rdata),
    .frame_done_o(frame_done), .busy_o(busy)
  );

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (reg_we) begin
      we_cnt++;
      wr_addr_q.push_back(reg_addr);
      wr_data_q.push_back(reg_wdata);
    end
    re_seen = reg_re;
    if (reg_re) begin
      re_cnt++;
      re_addr = reg_addr;
    end
    if (frame_done) fd_cnt++;
  end

  // Register bank: read data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (re_seen) reg_rdata <= bank[re_addr];
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic spi_bit(input logic b, input int half, output logic rx);
    mosi = b;
    repeat (half) @(negedge clk);
    rx = miso;
    sck = 1'b1;
    repeat (half) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int half, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], half, b);
      rx[i] = b;
    end
  endtask

  task automatic sel_low();
    ssn = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic sel_high();
    repeat (4) @(negedge clk);
    ssn = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    if ({miso, miso_oe, reg_we, reg_re, frame_done, busy} !== 6'b0) begin
      bad++; $display("[TB] FAIL reset_ctrl: got %b expected 000000", {miso, miso_oe, reg_we, reg_re, frame_done, busy});
    end
    total++;
    if (reg_addr !== 7'h00) begin
      bad++; $display("[TB] FAIL reset_addr: got %h expected 00", reg_addr);
    end
    total++;
    if (reg_wdata !== 8'h00) begin
      bad++; $display("[TB] FAIL reset_wdata: got %h expected 00", reg_wdata);
    end
    total++;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    if ({busy, miso_oe} !== 2'b00) begin
      bad++; $display("[TB] FAIL post_reset_idle: got %b expected 00", {busy, miso_oe});
    end
    total++;
  endtask

  task automatic test_single_write();
    int we0, fd0, q0;
    logic [7:0] rx;
    we0 = we_cnt; fd0 = fd_cnt; q0 = wr_addr_q.size();
    sel_low();
    if (miso_oe !== 1'b1) begin
      bad++; $display("[TB] FAIL write_oe: got %b expected 1", miso_oe);
    end
    total++;
    spi_byte(8'h05, 5, rx);
    spi_byte(8'hA5, 5, rx);
    repeat (4) @(negedge clk);
    if (fd_cnt - fd0 !== 0) begin
      bad++; $display("[TB] FAIL write_fd_early: got %0d expected 0", fd_cnt - fd0);
    end
    total++;
    sel_high();
    if (we_cnt - we0 !== 1) begin
      bad++; $display("[TB] FAIL write_we_count: got %0d expected 1", we_cnt - we0);
    end
    total++;
    if (wr_addr_q.size() > q0) begin
      if (wr_addr_q[q0] !== 7'h05 || wr_data_q[q0] !== 8'hA5) begin
        bad++; $display("[TB] FAIL write_data: got %h/%h expected 05/a5", wr_addr_q[q0], wr_data_q[q0]);
      end
    end else begin
      bad++; $display("[TB] FAIL write_data: got no write expected 05/a5");
    end
    total++;
    if (fd_cnt - fd0 !== 1) begin
      bad++; $display("[TB] FAIL write_fd: got %0d expected 1", fd_cnt - fd0);
    end
    total++;
  endtask

  task automatic test_burst_read();
    int re0;
    logic [7:0] rx;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    bank[7'h10] = 8'h11; bank[7'h11] = 8'h22; bank[7'h12] = 8'h33; bank[7'h13] = 8'h44;
    re0 = re_cnt;
    sel_low();
    spi_byte(8'h90, 5, rx);
    if (rx !== 8'h00) begin
      bad++; $display("[TB] FAIL read_cmd_miso: got %h expected 00", rx);
    end
    total++;
    for (int k = 0; k < 3; k++) begin
      spi_byte(8'h00, 5, rx);
      if (rx !== exp_b[k]) begin
        bad++; $display("[TB] FAIL read_byte%0d: got %h expected %h", k, rx, exp_b[k]);
      end
      total++;
    end
    sel_high();
    if (re_cnt - re0 !== 4) begin
      bad++; $display("[TB] FAIL read_re_count: got %0d expected 4", re_cnt - re0);
    end
    total++;
  endtask

  task automatic test_addr_wrap();
    int q0;
    logic [7:0] rx;
    q0 = wr_addr_q.size();
    sel_low();
    spi_byte(8'h7F, 5, rx);
    spi_byte(8'h01, 5, rx);
    spi_byte(8'h02, 5, rx);
    sel_high();
    if (wr_addr_q.size() - q0 !== 2) begin
      bad++; $display("[TB] FAIL wrap_count: got %0d expected 2", wr_addr_q.size() - q0);
    end else begin
      if (wr_addr_q[q0] !== 7'h7F || wr_data_q[q0] !== 8'h01) begin
        bad++; $display("[TB] FAIL wrap_first: got %h/%h expected 7f/01", wr_addr_q[q0], wr_data_q[q0]);
      end
      total++;
      if (wr_addr_q[q0+1] !== 7'h00 || wr_data_q[q0+1] !== 8'h02) begin
        bad++; $display("[TB] FAIL wrap_second: got %h/%h expected 00/02", wr_addr_q[q0+1], wr_data_q[q0+1]);
      end
    end
    total++;
  endtask

  task automatic test_abort();
    int we0, fd0, q0;
    logic [7:0] rx;
    logic b;
    we0 = we_cnt; fd0 = fd_cnt;
    sel_low();
    spi_byte(8'h03, 5, rx);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, 5, b);
    sel_high();
    if (we_cnt - we0 !== 0) begin
      bad++; $display("[TB] FAIL abort_we: got %0d expected 0", we_cnt - we0);
    end
    total++;
    if (fd_cnt - fd0 !== 1) begin
      bad++; $display("[TB] FAIL abort_fd: got %0d expected 1", fd_cnt - fd0);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("[TB] FAIL abort_idle: got busy=%b expected 0", busy);
    end
    total++;
    q0 = wr_addr_q.size();
    sel_low();
    spi_byte(8'h03, 5, rx);
    spi_byte(8'h3C, 5, rx);
    sel_high();
    if (wr_addr_q.size() - q0 !== 1) begin
      bad++; $display("[TB] FAIL abort_next_count: got %0d expected 1", wr_addr_q.size() - q0);
    end else if (wr_addr_q[q0] !== 7'h03 || wr_data_q[q0] !== 8'h3C) begin
      bad++; $display("[TB] FAIL abort_next_data: got %h/%h expected 03/3c", wr_addr_q[q0], wr_data_q[q0]);
    end
    total++;
  endtask

  task automatic test_reset_mid_read();
    int we0, re0, fd0, q0;
    logic [7:0] rx;
    logic [3:0] nib;
    logic b;
    bank[7'h10] = 8'h11;
    sel_low();
    spi_byte(8'h90, 5, rx);
    for (int i = 3; i >= 0; i--) begin
      spi_bit(1'b0, 5, b);
      nib[i] = b;
    end
    if (nib !== 4'h1) begin
      bad++; $display("[TB] FAIL rst_read_nibble: got %h expected 1", nib);
    end
    total++;
    mosi = 1'b0;
    repeat (2) @(negedge clk);
    sck = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    we0 = we_cnt; re0 = re_cnt; fd0 = fd_cnt;
    if ({miso, busy, miso_oe} !== 3'b000) begin
      bad++; $display("[TB] FAIL rst_outputs: got %b expected 000", {miso, busy, miso_oe});
    end
    total++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) sck = 1'b0;
      repeat (4) @(negedge clk);
      sck = 1'b1;
      repeat (4) @(negedge clk);
    end
    sck = 1'b0;
    ssn = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    if ((we_cnt - we0) + (re_cnt - re0) + (fd_cnt - fd0) !== 0) begin
      bad++; $display("[TB] FAIL rst_no_strobes: got %0d expected 0", (we_cnt - we0) + (re_cnt - re0) + (fd_cnt - fd0));
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("[TB] FAIL rst_busy: got %b expected 0", busy);
    end
    total++;
    q0 = wr_addr_q.size();
    sel_low();
    spi_byte(8'h01, 5, rx);
    spi_byte(8'h5A, 5, rx);
    sel_high();
    if (wr_addr_q.size() - q0 !== 1) begin
      bad++; $display("[TB] FAIL rst_fresh_count: got %0d expected 1", wr_addr_q.size() - q0);
    end else if (wr_addr_q[q0] !== 7'h01 || wr_data_q[q0] !== 8'h5A) begin
      bad++; $display("[TB] FAIL rst_fresh_data: got %h/%h expected 01/5a", wr_addr_q[q0], wr_data_q[q0]);
    end
    total++;
  endtask

  task automatic test_min_timing();
    int we0, re0, fd0;
    logic [7:0] rx;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hC3; exp_b[1] = 8'h5A; exp_b[2] = 8'h96; exp_b[3] = 8'h0F;
    for (int k = 0; k < 4; k++) bank[7'h20 + k] = exp_b[k];
    re0 = re_cnt;
    sel_low();
    spi_byte(8'hA0, 4, rx);
    for (int k = 0; k < 4; k++) begin
      spi_byte(8'hFF, 4, rx);
      if (rx !== exp_b[k]) begin
        bad++; $display("[TB] FAIL fast_byte%0d: got %h expected %h", k, rx, exp_b[k]);
      end
      total++;
    end
    sel_high();
    if (re_cnt - re0 !== 5) begin
      bad++; $display("[TB] FAIL fast_re_count: got %0d expected 5", re_cnt - re0);
    end
    total++;
    we0 = we_cnt; re0 = re_cnt; fd0 = fd_cnt;
    for (int i = 0; i < 12; i++) begin
      mosi = i[0];
      sck = ~sck;
      repeat (3) @(negedge clk);
    end
    sck = 1'b0;
    repeat (6) @(negedge clk);
    if ((we_cnt - we0) + (re_cnt - re0) + (fd_cnt - fd0) !== 0 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL noise_activity: got strobes=%0d busy=%b expected 0/0",
                      (we_cnt - we0) + (re_cnt - re0) + (fd_cnt - fd0), busy);
    end
    total++;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) bank[i] = 8'h00;
    test_reset();
    test_single_write();
    test_burst_read();
    test_addr_wrap();
    test_abort();
    test_reset_mid_read();
    test_min_timing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
